// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants: PC unit command encodings and fetch sequencer states.
package fetch_unit_pkg;

  localparam logic [1:0] PC_NOP   = 2'b00;
  localparam logic [1:0] PC_INC   = 2'b01;
  localparam logic [1:0] PC_SET   = 2'b10;
  localparam logic [1:0] PC_RESET = 2'b11;

  typedef enum logic [1:0] {
    S_START     = 2'b00,
    S_FETCH     = 2'b01,
    S_FETCH_IMM = 2'b10,
    S_ISSUE     = 2'b11
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer driving the PC unit, a single-cycle-ack read port and the decoder.
// Optional FETCH_STALL_CNT_EN adds a saturating stall_cnt output.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned LONG_BIT = 15,
  parameter int unsigned PC_STEP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_cur,
  output logic [1:0]  pc_op_o,
  output logic        pc_en_o,
  output logic [15:0] pc_set_o,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  output logic [15:0] instr_o,
  output logic [15:0] imm_o,
  output logic [15:0] instr_pc_o,
  output logic        instr_valid,
  input  logic        instr_ready
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  fetch_state_t state_q, state_d;
  logic         cap_instr;
  logic         cap_imm;

  // The PC unit owns the add; the step only documents the word size.
  if (PC_STEP == 0) begin : g_pc_step_zero
  end

  assign mem_addr = pc_cur;

  // Outputs are gated by rst so a reset cycle abandons any fetch at once.
  always_comb begin
    state_d     = state_q;
    pc_en_o     = 1'b0;
    pc_op_o     = PC_NOP;
    pc_set_o    = '0;
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    cap_instr   = 1'b0;
    cap_imm     = 1'b0;
    if (!rst) begin
      if (state_q == S_START) begin
        pc_en_o = 1'b1;
        pc_op_o = PC_RESET;
        state_d = S_FETCH;
      end else if (redirect) begin
        pc_en_o  = 1'b1;
        pc_op_o  = PC_SET;
        pc_set_o = redirect_addr;
        state_d  = S_FETCH;
      end else begin
        unique case (state_q)
          S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
              pc_en_o   = 1'b1;
              pc_op_o   = PC_INC;
              cap_instr = 1'b1;
              state_d   = mem_rdata[LONG_BIT] ? S_FETCH_IMM : S_ISSUE;
            end
          end
          S_FETCH_IMM: begin
            mem_req = 1'b1;
            if (mem_ack) begin
              pc_en_o = 1'b1;
              pc_op_o = PC_INC;
              cap_imm = 1'b1;
              state_d = S_ISSUE;
            end
          end
          S_ISSUE: begin
            instr_valid = 1'b1;
            if (instr_ready) state_d = S_FETCH;
          end
          default: state_d = S_START;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_START;
      instr_o    <= '0;
      imm_o      <= '0;
      instr_pc_o <= '0;
    end else begin
      state_q <= state_d;
      if (cap_instr) begin
        instr_o    <= mem_rdata;
        instr_pc_o <= pc_cur;
        if (!mem_rdata[LONG_BIT]) imm_o <= '0;
      end
      if (cap_imm) imm_o <= mem_rdata;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic stall_hit;

  assign stall_hit = (mem_req && !mem_ack) ||
                     (!rst && state_q == S_ISSUE && !instr_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_hit && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_cur;
  logic [1:0]  pc_op_o;
  logic        pc_en_o;
  logic [15:0] pc_set_o;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic [15:0] instr_o;
  logic [15:0] imm_o;
  logic [15:0] instr_pc_o;
  logic        instr_valid;
  logic        instr_ready;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  fetch_unit #(.LONG_BIT(15), .PC_STEP(2)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur),
    .pc_op_o(pc_op_o), .pc_en_o(pc_en_o), .pc_set_o(pc_set_o),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .instr_o(instr_o), .imm_o(imm_o), .instr_pc_o(instr_pc_o),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Environment: word-addressed memory and a registered PC unit obeying the commands.
  logic [15:0] memory [256];
  logic [15:0] pc_model = 16'hAAAA;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return memory[a[8:1]];
  endfunction

  assign pc_cur    = pc_model;
  assign mem_rdata = mem_ack ? mem_word(mem_addr) : 16'h0000;

  always @(posedge clk) begin
    if (pc_en_o) begin
      case (pc_op_o)
        PC_INC:   pc_model <= pc_model + 16'd2;
        PC_SET:   pc_model <= pc_set_o;
        PC_RESET: pc_model <= 16'h0000;
        default:  pc_model <= pc_model;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Model: an instruction is assembled from captured words; once complete it is held for the decoder.
  bit          m_fresh = 1'b1;
  bit          m_hold  = 1'b0;
  int unsigned m_n     = 0;
  logic [15:0] m_word0, m_word1, m_pc0;
  logic [31:0] m_stall = '0;

  always @(negedge clk) begin
    logic       e_en, e_req, e_val, in_issue, hit;
    logic [1:0] e_op;
    logic [15:0] e_set;
    e_en = 1'b0; e_req = 1'b0; e_val = 1'b0; e_op = PC_NOP; e_set = '0;
    in_issue = !rst && !m_fresh && m_hold;
`ifdef FETCH_STALL_CNT_EN
    chk("m_stall_cnt", stall_cnt, m_stall);
`endif
    if (rst) begin
      m_fresh = 1'b1; m_hold = 1'b0; m_n = 0;
    end else if (m_fresh) begin
      e_en = 1'b1; e_op = PC_RESET; m_fresh = 1'b0;
    end else if (redirect) begin
      e_en = 1'b1; e_op = PC_SET; e_set = redirect_addr; m_hold = 1'b0; m_n = 0;
    end else if (m_hold) begin
      e_val = 1'b1;
      chk("m_instr", instr_o, m_word0);
      chk("m_imm", imm_o, (m_n == 2) ? m_word1 : 16'h0000);
      chk("m_instr_pc", instr_pc_o, m_pc0);
      if (instr_ready) begin m_hold = 1'b0; m_n = 0; end
    end else begin
      e_req = 1'b1;
      if (mem_ack) begin
        e_en = 1'b1; e_op = PC_INC;
        if (m_n == 0) begin
          m_word0 = mem_word(pc_model); m_pc0 = pc_model; m_n = 1; m_hold = !m_word0[15];
        end else begin
          m_word1 = mem_word(pc_model); m_n = 2; m_hold = 1'b1;
        end
      end
    end
    hit = (e_req && !mem_ack) || (in_issue && !instr_ready);
    if (rst) m_stall = '0;
    else if (hit && m_stall != '1) m_stall = m_stall + 32'd1;
    chk("m_pc_en", pc_en_o, e_en);
    chk("m_pc_op", pc_op_o, e_op);
    chk("m_mem_req", mem_req, e_req);
    chk("m_instr_valid", instr_valid, e_val);
    if (e_en && e_op == PC_SET) chk("m_pc_set", pc_set_o, e_set);
    if (e_req) chk("m_mem_addr", mem_addr, pc_model);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned en_cnt;
    for (int i = 0; i < 256; i++) memory[i] = 16'($urandom);
    memory[0] = 16'h1234;
    memory[1] = 16'h8001;
    memory[2] = 16'hBEEF;
    memory[3] = 16'h8002;
    rst = 1'b1; mem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_addr = '0;
    repeat (2) tick();

    rst = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    chk("t1_reset_en", pc_en_o, 1'b1);
    chk("t1_reset_op", pc_op_o, PC_RESET);
    tick(); @(negedge clk);
    chk("t1_fetch_req", mem_req, 1'b1);
    chk("t1_fetch_addr", mem_addr, 16'h0000);
    chk("t1_fetch_inc", pc_op_o, PC_INC);
    tick(); @(negedge clk);
    chk("t1_valid", instr_valid, 1'b1);
    chk("t1_instr", instr_o, 16'h1234);
    chk("t1_imm", imm_o, 16'h0000);
    chk("t1_instr_pc", instr_pc_o, 16'h0000);
    repeat (4) begin
      tick(); @(negedge clk);
      chk("t4_hold_valid", instr_valid, 1'b1);
      chk("t4_hold_instr", instr_o, 16'h1234);
      chk("t4_no_req", mem_req, 1'b0);
      chk("t4_no_cmd", pc_en_o, 1'b0);
    end
    tick(); instr_ready = 1'b1; @(negedge clk);
    tick(); instr_ready = 1'b0; @(negedge clk);
    chk("t2_fetch_addr", mem_addr, 16'h0002);
    chk("t2_fetch_inc", pc_op_o, PC_INC);
`ifdef FETCH_STALL_CNT_EN
    chk("t4_stall_cnt", stall_cnt, 32'd5);
`endif
    tick(); @(negedge clk);
    chk("t2_imm_addr", mem_addr, 16'h0004);
    chk("t2_imm_inc", pc_op_o, PC_INC);
    tick(); instr_ready = 1'b1; @(negedge clk);
    chk("t2_valid", instr_valid, 1'b1);
    chk("t2_instr", instr_o, 16'h8001);
    chk("t2_imm", imm_o, 16'hBEEF);
    chk("t2_instr_pc", instr_pc_o, 16'h0002);

    tick(); instr_ready = 1'b0; mem_ack = 1'b0; en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ack = 1'b1;
      @(negedge clk);
      chk("t3_req", mem_req, 1'b1);
      chk("t3_addr", mem_addr, 16'h0006);
      en_cnt += 32'(pc_en_o);
      if (i < 3) tick();
    end
    chk("t3_one_inc", en_cnt, 1);

    tick(); redirect = 1'b1; redirect_addr = 16'h0100; @(negedge clk);
    chk("t5_set_en", pc_en_o, 1'b1);
    chk("t5_set_op", pc_op_o, PC_SET);
    chk("t5_set_val", pc_set_o, 16'h0100);
    chk("t5_no_valid", instr_valid, 1'b0);
    tick(); redirect = 1'b0; mem_ack = 1'b0; @(negedge clk);
    chk("t5_new_req", mem_req, 1'b1);
    chk("t5_new_addr", mem_addr, 16'h0100);
    chk("t5_no_valid2", instr_valid, 1'b0);
`ifdef FETCH_STALL_CNT_EN
    chk("t3_stall_cnt", stall_cnt, 32'd8);
`endif
    tick(); rst = 1'b1; @(negedge clk);
    chk("t6_rst_req", mem_req, 1'b0);
    chk("t6_rst_en", pc_en_o, 1'b0);
    tick(); rst = 1'b0; @(negedge clk);
    chk("t6_reset_en", pc_en_o, 1'b1);
    chk("t6_reset_op", pc_op_o, PC_RESET);
`ifdef FETCH_STALL_CNT_EN
    chk("t6_stall_clr", stall_cnt, 32'd0);
`endif

    for (int c = 0; c < 3000; c++) begin
      tick();
      rst           = ($urandom_range(0, 99) == 0);
      mem_ack       = ($urandom_range(0, 9) < 6);
      instr_ready   = ($urandom_range(0, 9) < 6);
      redirect      = ($urandom_range(0, 15) == 0);
      redirect_addr = 16'($urandom_range(0, 255)) << 1;
    end
    tick(); rst = 1'b0; redirect = 1'b0;
    repeat (3) tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
